ram_dp: RTL
===========

# ram_dp

Dual-port synchronous RAM for the asm18 core: port A is read/write (data side), port B is read-only (instruction fetch side). It generalises the single-port sync RAM with:
- a second port;
- read strobes with valid flags;
- an optional output pipeline stage;
- defined out-of-range behaviour;
- an optional clear-on-reset sweeper.

It sits between the CPU core and its local memory; both ports share one clock.

## Interface
- ADDR_SIZE, 18, address width of both ports
- WORD_SIZE, 18, data word width
- MEM_SIZE, 1024, number of words; must be ≤ 2^ADDR_SIZE
- OUT_REG, 0, 1 adds one output register stage on both ports

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_we  in  1  port A write strobe
- a_re  in  1  port A read strobe
- a_addr  in  ADDR_SIZE  port A address
- a_din  in  WORD_SIZE  port A write data
- a_dout  out  WORD_SIZE  port A read data, held until next valid read
- a_rvalid  out  1  one-cycle pulse: a_dout carries new read data
- b_re  in  1  port B read strobe
- b_addr  in  ADDR_SIZE  port B address
- b_dout  out  WORD_SIZE  port B read data, held until next valid read
- b_rvalid  out  1  one-cycle pulse: b_dout carries new read data
- ready  out  1  1 = array accepts accesses

## Operation
- Reset values: a_dout=0, b_dout=0, a_rvalid=0, b_rvalid=0, ready=0. The output pipeline registers also clear to 0.
- FSM states: CLEAR and RUN. Reset enters CLEAR when RAM_CLEAR_EN is defined, otherwise RUN. CLEAR advances to RUN after writing the last address.
- The ready output is 1 only in RUN.
- While ready=0, all strobes are ignored: no write, no rvalid, dout unchanged.
- Write: a_we=1 with a_addr < MEM_SIZE writes a_din at the edge.
- Read: a_re or b_re with an in-range address returns mem[addr] after the latency and pulses rvalid.
- Out of range (addr ≥ MEM_SIZE):
  - writes are dropped;
  - reads return 0 and still pulse rvalid.
- a_we and a_re together, same port: read-first, so a_dout returns the old word.
- Port B read of the address port A writes in the same cycle: write-through, so b_dout returns a_din.
- Back-to-back reads are allowed every cycle on both ports, with no bubbles.
- Asserting reset_n low mid-operation:
  - immediately clears all outputs and any in-flight pipeline data;
  - the FSM restarts from its reset state.

## Timing
- Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), counted from the edge sampling the strobe to the edge updating dout and asserting rvalid.
- Each rvalid pulse lasts exactly one cycle per accepted strobe.
- Writes are visible to port A reads issued on the following cycle. Port B sees them in the same cycle via forwarding.
- CLEAR takes exactly MEM_SIZE cycles: addresses 0..MEM_SIZE-1 are written 0, one per cycle. ready rises on the edge after address MEM_SIZE-1 is written.
- Without RAM_CLEAR_EN, ready rises on the first rising edge after reset_n deasserts.
- Reset deassertion must meet recovery timing to clock. Synchronising reset_n is the integrator's job.

## Configuration
- Macro: RAM_CLEAR_EN.
- Defined:
  - the sweep counter and CLEAR state are compiled in;
  - memory is all-zero when ready rises.
- Undefined:
  - no sweeper logic;
  - memory content after reset is undefined (X in simulation) and reset does not touch the array;
  - ready=1 one cycle after reset release.

## Test plan
- Reset, RAM_CLEAR_EN defined, MEM_SIZE=16 -> ready=0 for exactly 16 cycles after release. A read of addr 5 issued once ready=1 returns 0 with one rvalid pulse.
- Write 0x2ABCD to addr 3, then read port A on the next cycle -> a_dout=0x2ABCD one cycle later (OUT_REG=0) or two cycles later (OUT_REG=1). a_rvalid high exactly one cycle.
- Same cycle: a_we=1 addr 7 din 0x12345, a_re=1 addr 7, b_re=1 addr 7, with old content 0x00011 -> a_dout=0x00011, b_dout=0x12345.
- Write 0x3FFFF to addr MEM_SIZE (out of range), then read addr MEM_SIZE and addr 0 -> both return 0 with rvalid. The addr 0 content is unchanged.
- Continuous b_re for 8 cycles over addrs 0..7 holding 0x100+i -> 8 consecutive b_rvalid pulses, data in order, no gaps.
- Pull reset_n low during a read in flight with OUT_REG=1 -> a_dout=0 and a_rvalid=0 immediately. The pending read never produces rvalid, and ready=0 until the sweep (if built in) completes.

Source files
------------

// File: rtl/ram_dp.sv
// rtl/ram_dp.sv - dual-port sync RAM, port A read/write, port B read-only
// Optional clear-on-reset sweeper: define RAM_CLEAR_EN.
module ram_dp #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MEM_SIZE  = 1024,
  parameter int OUT_REG   = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_we,
  input  logic                 a_re,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_din,
  output logic [WORD_SIZE-1:0] a_dout,
  output logic                 a_rvalid,
  input  logic                 b_re,
  input  logic [ADDR_SIZE-1:0] b_addr,
  output logic [WORD_SIZE-1:0] b_dout,
  output logic                 b_rvalid,
  output logic                 ready
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_SIZE:0] MEM_LIMIT = (ADDR_SIZE+1)'(MEM_SIZE);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state, state_next;
  logic                 ready_q;
  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  logic                 a_in, b_in, a_wr, a_hit, b_hit;
  logic [IDX_W-1:0]     a_idx, b_idx;
  logic [WORD_SIZE-1:0] a_rdata, b_rdata;
  logic                 a_v1, b_v1;
  logic [WORD_SIZE-1:0] a_d1, b_d1;

`ifdef RAM_CLEAR_EN
  localparam state_t           RESET_STATE = ST_CLEAR;
  localparam logic [IDX_W-1:0] CLR_LAST    = IDX_W'(MEM_SIZE - 1);
  logic [IDX_W-1:0] clr_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      clr_idx <= '0;
    else if (state == ST_CLEAR)
      clr_idx <= clr_idx + 1'b1;
  end

  always_comb begin
    state_next = state;
    if (state == ST_CLEAR && clr_idx == CLR_LAST)
      state_next = ST_RUN;
  end
`else
  localparam state_t RESET_STATE = ST_RUN;

  always_comb begin
    state_next = state;
  end
`endif

  // ready is registered so it stays low for the first edge out of reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RESET_STATE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ST_RUN);
    end
  end

  assign ready = ready_q;

  assign a_in  = {1'b0, a_addr} < MEM_LIMIT;
  assign b_in  = {1'b0, b_addr} < MEM_LIMIT;
  assign a_idx = a_addr[IDX_W-1:0];
  assign b_idx = b_addr[IDX_W-1:0];
  assign a_wr  = ready_q && a_we && a_in;
  assign a_hit = ready_q && a_re;
  assign b_hit = ready_q && b_re;

  always_ff @(posedge clock) begin
`ifdef RAM_CLEAR_EN
    if (state == ST_CLEAR)
      mem[clr_idx] <= '0;
`endif
    if (a_wr)
      mem[a_idx] <= a_din;
  end

  // port A is read-first; port B forwards a same-cycle port A write
  assign a_rdata = a_in ? mem[a_idx] : '0;
  assign b_rdata = !b_in ? '0 : ((a_wr && a_addr == b_addr) ? a_din : mem[b_idx]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_hit;
      b_v1 <= b_hit;
      if (a_hit) a_d1 <= a_rdata;
      if (b_hit) b_d1 <= b_rdata;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_rvalid <= 1'b0;
          b_rvalid <= 1'b0;
          a_dout   <= '0;
          b_dout   <= '0;
        end else begin
          a_rvalid <= a_v1;
          b_rvalid <= b_v1;
          if (a_v1) a_dout <= a_d1;
          if (b_v1) b_dout <= b_d1;
        end
      end
    end else begin : g_direct
      assign a_rvalid = a_v1;
      assign b_rvalid = b_v1;
      assign a_dout   = a_d1;
      assign b_dout   = b_d1;
    end
  endgenerate

endmodule
